// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo buffer: transmit FSM states,
// the CR line terminator and the lower-to-upper case conversion helper.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SETTLE,
    WAIT
  } tx_state_e;

  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] LOWER_A     = 8'h61;
  localparam logic [7:0] LOWER_Z     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= LOWER_A && b <= LOWER_Z) ? b - CASE_OFFSET : b;
  endfunction

endpackage

// File: rtl/uart_echo_fifo_if.sv
// Byte-level link between the UART receiver/transmitter and the echo buffer.
// The master side feeds received bytes and transmitter status; the slave side is the buffer.
interface uart_echo_fifo_if;

  logic       rx_rcv;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    output rx_rcv, rx_data, tx_ready,
    input  tx_start, tx_data
  );

  modport slave (
    input  rx_rcv, rx_data, tx_ready,
    output tx_start, tx_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; dout is a register loaded on pop, head peeks the oldest entry.
// A push while full is taken only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] dout_q;
  logic             wr_en, rd_en;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign level = level_q;
  assign dout  = dout_q;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffers received UART bytes and echoes them to the transmitter, optionally
// upper-casing them and holding output until a full line (CR) has arrived.
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int UPCASE    = 0,
  parameter  int LINE_MODE = 0,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_echo_fifo_if.slave     bus,
  output logic [LW-1:0]       level,
  output logic                overflow,
  output logic [7:0]          last_rx
);

  tx_state_e   state_q, state_d;
  logic        tx_start_q;
  logic        overflow_q;
  logic [7:0]  last_rx_q;
  logic [LW-1:0] cr_cnt_q, cr_cnt_d;
  logic        flush_q;

  logic [7:0]  wr_byte, fifo_head, fifo_dout;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic        push_ok, cr_in, cr_out, release_ok;

  assign wr_byte = (UPCASE != 0) ? to_upper(bus.rx_data) : bus.rx_data;
  assign push_ok = bus.rx_rcv && (!fifo_full || fifo_pop);
  assign cr_in   = push_ok && (wr_byte == CR);
  assign cr_out  = fifo_pop && (fifo_head == CR);

  // A full buffer with no CR would never drain; once full, keep releasing until empty.
  assign release_ok = (LINE_MODE == 0) || (cr_cnt_q != '0) || fifo_full || flush_q;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.rx_rcv),
    .din   (wr_byte),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .head  (fifo_head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.tx_ready && release_ok) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START:  state_d = SETTLE;
      SETTLE: state_d = WAIT;
      WAIT:   if (bus.tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cr_cnt_d = cr_cnt_q;
    case ({cr_in, cr_out})
      2'b10:   cr_cnt_d = cr_cnt_q + LW'(1);
      2'b01:   cr_cnt_d = cr_cnt_q - LW'(1);
      default: cr_cnt_d = cr_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
      last_rx_q  <= '0;
      cr_cnt_q   <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= (state_q == START);
      cr_cnt_q   <= cr_cnt_d;
      if (bus.rx_rcv) last_rx_q <= bus.rx_data;
      if (bus.rx_rcv && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      if (LINE_MODE != 0 && fifo_full) flush_q <= 1'b1;
      else if (fifo_empty)             flush_q <= 1'b0;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = fifo_dout;
  assign overflow     = overflow_q;
  assign last_rx      = last_rx_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo across four parameter sets sharing one clock and reset.
module tb_uart_echo_fifo;
  import uart_echo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  uart_echo_fifo_if ifa ();
  uart_echo_fifo_if ifb ();
  uart_echo_fifo_if ifc ();
  uart_echo_fifo_if ifd ();

  logic [4:0] lvl_a, lvl_b;
  logic [2:0] lvl_c, lvl_d;
  logic       ov_a, ov_b, ov_c, ov_d;
  logic [7:0] lrx_a, lrx_b, lrx_c, lrx_d;

  uart_echo_fifo #(.DEPTH(16), .UPCASE(0), .LINE_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .level(lvl_a), .overflow(ov_a), .last_rx(lrx_a));
  uart_echo_fifo #(.DEPTH(16), .UPCASE(1), .LINE_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .level(lvl_b), .overflow(ov_b), .last_rx(lrx_b));
  uart_echo_fifo #(.DEPTH(4), .UPCASE(0), .LINE_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc), .level(lvl_c), .overflow(ov_c), .last_rx(lrx_c));
  uart_echo_fifo #(.DEPTH(4), .UPCASE(0), .LINE_MODE(1)) dut_d (
    .clk(clk), .rst(rst), .bus(ifd), .level(lvl_d), .overflow(ov_d), .last_rx(lrx_d));

  logic [7:0] qb[$];
  logic [7:0] qc[$];
  logic [7:0] qd[$];

  always @(negedge clk) begin
    if (ifb.tx_start === 1'b1) qb.push_back(ifb.tx_data);
    if (ifc.tx_start === 1'b1) qc.push_back(ifc.tx_data);
    if (ifd.tx_start === 1'b1) qd.push_back(ifd.tx_data);
  end

  task automatic send(input int sel, input logic [7:0] b);
    case (sel)
      0: begin ifa.rx_rcv = 1'b1; ifa.rx_data = b; end
      1: begin ifb.rx_rcv = 1'b1; ifb.rx_data = b; end
      2: begin ifc.rx_rcv = 1'b1; ifc.rx_data = b; end
      default: begin ifd.rx_rcv = 1'b1; ifd.rx_data = b; end
    endcase
    @(negedge clk);
    ifa.rx_rcv = 1'b0; ifb.rx_rcv = 1'b0; ifc.rx_rcv = 1'b0; ifd.rx_rcv = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (lvl_a !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", lvl_a); end
    total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", ov_a); end
    total++; if (ifa.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", ifa.tx_start); end
    total++; if (ifa.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", ifa.tx_data); end
    total++; if (lrx_a !== 8'h00) begin bad++; $display("FAIL reset_last_rx got=%h want=00", lrx_a); end
    total++; if (dut_d.cr_cnt_q !== 3'd0) begin bad++; $display("FAIL reset_cr_cnt got=%0d want=0", dut_d.cr_cnt_q); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    ifa.tx_ready = 1'b1;
    send(0, 8'h41);
    total++; if (lvl_a !== 5'd1) begin bad++; $display("FAIL lat_level_n got=%0d want=1", lvl_a); end
    total++; if (ifa.tx_start !== 1'b0) begin bad++; $display("FAIL lat_start_n got=%b want=0", ifa.tx_start); end
    @(negedge clk);
    total++; if (ifa.tx_start !== 1'b0) begin bad++; $display("FAIL lat_start_n1 got=%b want=0", ifa.tx_start); end
    total++; if (lvl_a !== 5'd0) begin bad++; $display("FAIL lat_level_n1 got=%0d want=0", lvl_a); end
    @(negedge clk);
    total++; if (ifa.tx_start !== 1'b1) begin bad++; $display("FAIL lat_start_n2 got=%b want=1", ifa.tx_start); end
    total++; if (ifa.tx_data !== 8'h41) begin bad++; $display("FAIL lat_data got=%h want=41", ifa.tx_data); end
    @(negedge clk);
    total++; if (ifa.tx_start !== 1'b0) begin bad++; $display("FAIL lat_start_pulse got=%b want=0", ifa.tx_start); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_upcase();
    logic [7:0] exp [0:3];
    exp = '{8'h60, 8'h41, 8'h5A, 8'h7B};
    qb.delete();
    ifb.tx_ready = 1'b1;
    send(1, 8'h60); send(1, 8'h61); send(1, 8'h7A); send(1, 8'h7B);
    repeat (25) @(negedge clk);
    total++; if (qb.size() != 4) begin bad++; $display("FAIL upcase_count got=%0d want=4", qb.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (qb[i] !== exp[i]) begin bad++; $display("FAIL upcase_byte%0d got=%h want=%h", i, qb[i], exp[i]); end
    end
    total++; if (lrx_b !== 8'h7B) begin bad++; $display("FAIL upcase_last_rx got=%h want=7b", lrx_b); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [0:3];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    qc.delete();
    ifc.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2, exp[i]);
    total++; if (ov_c !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b want=0", ov_c); end
    send(2, 8'h55);
    total++; if (lvl_c !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", lvl_c); end
    total++; if (ov_c !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ov_c); end
    total++; if (lrx_c !== 8'h55) begin bad++; $display("FAIL ovf_last_rx got=%h want=55", lrx_c); end
    total++; if (qc.size() != 0) begin bad++; $display("FAIL ovf_held got=%0d want=0", qc.size()); end
    ifc.tx_ready = 1'b1;
    repeat (25) @(negedge clk);
    total++; if (qc.size() != 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", qc.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (qc[i] !== exp[i]) begin bad++; $display("FAIL ovf_byte%0d got=%h want=%h", i, qc[i], exp[i]); end
    end
    total++; if (ov_c !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ov_c); end
    total++; if (lvl_c !== 3'd0) begin bad++; $display("FAIL ovf_drained got=%0d want=0", lvl_c); end
  endtask

  task automatic test_line_mode();
    logic [7:0] exp [0:2];
    logic [7:0] fl [0:3];
    exp = '{8'h41, 8'h42, 8'h0D};
    fl  = '{8'h31, 8'h32, 8'h33, 8'h34};
    qd.delete();
    ifd.tx_ready = 1'b1;
    send(3, 8'h41); send(3, 8'h42);
    repeat (10) @(negedge clk);
    total++; if (qd.size() != 0) begin bad++; $display("FAIL line_held got=%0d want=0", qd.size()); end
    total++; if (lvl_d !== 3'd2) begin bad++; $display("FAIL line_level got=%0d want=2", lvl_d); end
    send(3, 8'h0D);
    total++; if (dut_d.cr_cnt_q !== 3'd1) begin bad++; $display("FAIL line_cr_up got=%0d want=1", dut_d.cr_cnt_q); end
    repeat (20) @(negedge clk);
    total++; if (qd.size() != 3) begin bad++; $display("FAIL line_count got=%0d want=3", qd.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (qd[i] !== exp[i]) begin bad++; $display("FAIL line_byte%0d got=%h want=%h", i, qd[i], exp[i]); end
    end
    total++; if (dut_d.cr_cnt_q !== 3'd0) begin bad++; $display("FAIL line_cr_end got=%0d want=0", dut_d.cr_cnt_q); end
    qd.delete();
    for (int i = 0; i < 3; i++) send(3, fl[i]);
    repeat (3) @(negedge clk);
    total++; if (qd.size() != 0) begin bad++; $display("FAIL flush_held got=%0d want=0", qd.size()); end
    send(3, fl[3]);
    repeat (25) @(negedge clk);
    total++; if (qd.size() != 4) begin bad++; $display("FAIL flush_count got=%0d want=4", qd.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (qd[i] !== fl[i]) begin bad++; $display("FAIL flush_byte%0d got=%h want=%h", i, qd[i], fl[i]); end
    end
    total++; if (lvl_d !== 3'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", lvl_d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [0:4];
    exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    qc.delete();
    ifc.tx_ready = 1'b0;
    send(2, 8'hA1); send(2, 8'hA2); send(2, 8'hA3); send(2, 8'hA4);
    ifc.tx_ready = 1'b1;
    @(negedge clk);
    ifc.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (lvl_c !== 3'd3) begin bad++; $display("FAIL mid_level got=%0d want=3", lvl_c); end
    total++; if (dut_c.state_q !== WAIT) begin bad++; $display("FAIL mid_state got=%0d want=%0d", dut_c.state_q, WAIT); end
    total++; if (qc.size() != 1) begin bad++; $display("FAIL mid_one_sent got=%0d want=1", qc.size()); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (lvl_c !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", lvl_c); end
    total++; if (ov_c !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", ov_c); end
    ifc.tx_ready = 1'b1;
    @(negedge clk);
    total++; if (ifc.tx_start !== 1'b0) begin bad++; $display("FAIL rst_no_start got=%b want=0", ifc.tx_start); end
    repeat (10) @(negedge clk);
    total++; if (qc.size() != 1) begin bad++; $display("FAIL rst_discard got=%0d want=1", qc.size()); end
    qc.delete();
    ifc.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2, exp[i]);
    total++; if (lvl_c !== 3'd4) begin bad++; $display("FAIL pp_full got=%0d want=4", lvl_c); end
    ifc.tx_ready = 1'b1;
    ifc.rx_rcv = 1'b1; ifc.rx_data = exp[4];
    @(negedge clk);
    ifc.tx_ready = 1'b0; ifc.rx_rcv = 1'b0;
    total++; if (lvl_c !== 3'd4) begin bad++; $display("FAIL pp_level got=%0d want=4", lvl_c); end
    total++; if (ov_c !== 1'b0) begin bad++; $display("FAIL pp_overflow got=%b want=0", ov_c); end
    ifc.tx_ready = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (qc.size() != 5) begin bad++; $display("FAIL pp_count got=%0d want=5", qc.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (qc[i] !== exp[i]) begin bad++; $display("FAIL pp_byte%0d got=%h want=%h", i, qc[i], exp[i]); end
    end
  endtask

  initial begin
    ifa.rx_rcv = 1'b0; ifa.rx_data = '0; ifa.tx_ready = 1'b0;
    ifb.rx_rcv = 1'b0; ifb.rx_data = '0; ifb.tx_ready = 1'b0;
    ifc.rx_rcv = 1'b0; ifc.rx_data = '0; ifc.tx_ready = 1'b0;
    ifd.rx_rcv = 1'b0; ifd.rx_data = '0; ifd.tx_ready = 1'b0;
    test_reset();
    test_latency();
    test_upcase();
    test_overflow();
    test_line_mode();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the FIFO capacity in bytes and SHALL be a power of two, 4..256.
REQ-002 Parameter UPCASE, default 0, SHALL convert 'a'..'z' (8'h61..8'h7A) to upper case on write when set to 1.
REQ-003 Parameter LINE_MODE, default 0, SHALL hold echo output until a CR byte (8'h0D) is buffered when set to 1.
REQ-004 Port clk, input, 1 bit, SHALL be the single system clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port rx_rcv, input, 1 bit, SHALL be a one-cycle strobe marking a received byte.
REQ-007 Port rx_data, input, 8 bits, SHALL carry the received byte and is valid when rx_rcv=1.
REQ-008 Port tx_ready, input, 1 bit, SHALL indicate that the transmitter is idle.
REQ-009 Port tx_start, output, 1 bit, SHALL be a one-cycle strobe requesting transmission of tx_data.
REQ-010 Port tx_data, output, 8 bits, SHALL carry the byte to send and be stable from tx_start until tx_ready returns to 1.
REQ-011 Port level, output, $clog2(DEPTH)+1 bits, SHALL give the current FIFO occupancy.
REQ-012 Port overflow, output, 1 bit, SHALL be a sticky flag for a dropped byte.
REQ-013 Port last_rx, output, 8 bits, SHALL hold the most recent received byte before case conversion (LED display).

Function
REQ-014 The write path SHALL store the byte in the FIFO on a cycle where rx_rcv=1 and the FIFO is not full, after UPCASE conversion.
REQ-015 The write path SHALL update last_rx on every rx_rcv=1, whether or not the FIFO is full.
REQ-016 On rx_rcv=1 with the FIFO full, the byte SHALL be dropped, overflow SHALL be set to 1, and FIFO contents SHALL be unchanged.
REQ-017 The transmit FSM SHALL use the states IDLE, START, SETTLE and WAIT.
REQ-018 IDLE SHALL go to START when the FIFO is not empty, tx_ready=1 and the release condition holds; in that same cycle it SHALL pop the head byte into the tx_data register.
REQ-019 START SHALL assert tx_start=1 for exactly one cycle, then go to SETTLE.
REQ-020 SETTLE SHALL ignore tx_ready for one cycle, to cover the transmitter's ready-deassert latency, then go to WAIT.
REQ-021 WAIT SHALL go to IDLE when tx_ready=1.
REQ-022 The release condition SHALL always be true when LINE_MODE=0.
REQ-023 When LINE_MODE=1, the release condition SHALL be true when the CR count is >0 or level=DEPTH; the full-buffer case is a deadlock-free flush.
REQ-024 The CR counter SHALL increment when a CR is written and decrement when a CR is popped; it is unchanged on a simultaneous CR write and CR pop.
REQ-025 A simultaneous push and pop SHALL leave level unchanged and keep data order.
REQ-026 A push on an empty FIFO SHALL be accepted.
REQ-027 A push on a full FIFO in the same cycle as a pop SHALL be accepted, since the pop frees a slot that cycle.
REQ-028 The minimum latency from rx_rcv to tx_start SHALL be 2 cycles: the write at edge N, the pop in IDLE at edge N+1, and tx_start high after edge N+2.
REQ-029 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full and empty SHALL be derived from level.

Reset
REQ-030 While rst=1 at a clock edge, the FSM SHALL go to IDLE; pointers, level, CR count, overflow, tx_start, tx_data and last_rx SHALL be set to 0.
REQ-031 Reset mid-transfer SHALL discard all buffered bytes and SHALL NOT produce a tx_start in the cycle after reset is released.
REQ-032 overflow SHALL be cleared only by rst.

Structure
REQ-033 Package uart_echo_pkg SHALL hold the FSM state enum, the CR constant (8'h0D) and the case-conversion bounds 8'h61/8'h7A and offset 8'h20.
REQ-034 Storage SHALL be the sub-module sync_fifo, parameterised by WIDTH=8 and DEPTH.
REQ-035 sync_fifo SHALL provide push, pop, dout, level, full and empty, with dout registered on pop.
REQ-036 The top-level wrapper SHALL connect uart_rx rcv/data to rx_rcv/rx_data and uart_tx start/data/ready to tx_start/tx_data/tx_ready; the wrapper is outside this block.

Verification
REQ-037 Scenario: defaults; send 8'h41; tx_ready=1 -> tx_start after 2 cycles, tx_data=8'h41, level back to 0.
REQ-038 Scenario: UPCASE=1; send 8'h61,8'h7A,8'h7B -> transmitted 8'h41,8'h5A,8'h7B; last_rx=8'h7B.
REQ-039 Scenario: DEPTH=4, tx_ready held 0; send 5 bytes -> level=4, overflow=1, fifth byte absent; release tx_ready -> first 4 bytes echoed in order.
REQ-040 Scenario: LINE_MODE=1; send "AB" -> no tx_start; send 8'h0D -> 8'h41,8'h42,8'h0D echoed, CR count ends at 0.
REQ-041 Scenario: LINE_MODE=1, DEPTH=4; send 4 non-CR bytes -> full-buffer flush echoes all 4.
REQ-042 Scenario: assert rst for 1 cycle while in WAIT with level=3 -> level=0, overflow=0, no further tx_start; then a push on the full FIFO in the same cycle as a pop is accepted with level unchanged.
